// File: rtl/bus_frame_pkg.sv
// Shared constants, state encoding and frame layout for the node-bus receiver.
package bus_frame_pkg;

    localparam int FRAME_LEN = 80;
    localparam int CNT_W     = 7;

    localparam int SRC_LSB   = 1;
    localparam int DST_LSB   = 5;
    localparam int DSZ_LSB   = 9;
    localparam int DATA_LSB  = 11;
    localparam int CRC_LSB   = 75;
    localparam int END_BIT   = 79;

    localparam int ADDR_W    = 4;
    localparam int DSZ_W     = 2;
    localparam int DATA_W    = 64;
    localparam int CRC_W     = 4;

    localparam logic [DSZ_W-1:0] DATASIZE_FULL = 2'b11;
    localparam logic [CNT_W-1:0] LAST_IDX      = CNT_W'(END_BIT);

    typedef enum logic [2:0] {
        ST_ARM,
        ST_IDLE,
        ST_SHIFT,
        ST_CHECK,
        ST_ACK
    } rx_state_e;

    // Field order mirrors the wire order: start bit lands at bit 0.
    typedef struct packed {
        logic              end_bit;
        logic [CRC_W-1:0]  crc;
        logic [DATA_W-1:0] data;
        logic [DSZ_W-1:0]  dsz;
        logic [ADDR_W-1:0] dst;
        logic [ADDR_W-1:0] src;
        logic              start_bit;
    } bus_frame_t;

endpackage

// File: rtl/frame_shift_reg.sv
// 80-bit capture register: each bus sample is written at the index given by
// the bit counter, so bit k of the frame is the sample taken k cycles after start.
module frame_shift_reg
    import bus_frame_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 shift_en,
    input  logic                 bit_in,
    output logic [FRAME_LEN-1:0] frame,
    output logic                 done
);

    logic [CNT_W-1:0] cnt;

    // Start writes bit 0; each shift cycle writes bit cnt. Counter holds at the last index.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frame <= '0;
            cnt   <= '0;
        end else if (start) begin
            frame[0] <= bit_in;
            cnt      <= CNT_W'(1);
        end else if (shift_en && (cnt <= LAST_IDX)) begin
            frame[cnt] <= bit_in;
            if (cnt != LAST_IDX) cnt <= cnt + CNT_W'(1);
        end
    end

    // Strobe in the cycle that stores the end bit.
    always_comb begin
        done = shift_en && (cnt == LAST_IDX);
    end

endmodule

// File: rtl/bus_frame_receiver.sv
// Single-wire node bus receiver: captures one frame, validates it, acks accepted
// frames and hands src/data to local logic over a one-entry valid/ready buffer.
// Optional error counters: define BUS_FRAME_RECEIVER_ERR_CNT_EN.
module bus_frame_receiver
    import bus_frame_pkg::*;
#(
    parameter int ACK_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              bus_in,
    input  logic [ADDR_W-1:0] my_addr,
    input  logic [CRC_W-1:0]  crc_ref,
    output logic              ack_en,
    output logic              ack_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_src,
    output logic [DATA_W-1:0] out_data,
`ifdef BUS_FRAME_RECEIVER_ERR_CNT_EN
    output logic [7:0]        err_crc_cnt,
    output logic [7:0]        err_frame_cnt,
    output logic [7:0]        err_ovf_cnt,
`endif
    output logic              err_pulse
);

    localparam int ACW = $clog2(ACK_CYCLES + 1);

    rx_state_e              state, state_nxt;
    logic [FRAME_LEN-1:0]   frame_bits;
    bus_frame_t             fr;
    logic                   sr_start, sr_shift, sr_done;
    logic [ACW-1:0]         ack_cnt;
    logic                   dst_hit, frame_ok, crc_ok, buf_free;
    logic                   accept, rej_frame, rej_crc, rej_ovf;

    frame_shift_reg u_shift (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (sr_start),
        .shift_en (sr_shift),
        .bit_in   (bus_in),
        .frame    (frame_bits),
        .done     (sr_done)
    );

    assign fr = bus_frame_t'(frame_bits);

    // Frame checks, in priority order: address, framing, CRC, buffer space.
    always_comb begin
        dst_hit   = (fr.dst == my_addr);
        frame_ok  = !fr.start_bit && fr.end_bit && (fr.dsz == DATASIZE_FULL);
        crc_ok    = (fr.crc == crc_ref);
        buf_free  = !out_valid || out_ready;
        rej_frame = (state == ST_CHECK) && dst_hit && !frame_ok;
        rej_crc   = (state == ST_CHECK) && dst_hit && frame_ok && !crc_ok;
        rej_ovf   = (state == ST_CHECK) && dst_hit && frame_ok && crc_ok && !buf_free;
        accept    = (state == ST_CHECK) && dst_hit && frame_ok && crc_ok && buf_free;
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= ST_ARM;
        else          state <= state_nxt;
    end

    // Next state. ARM waits for a high bus so trailing zeros are never a start.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ARM:   if (bus_in == 1'b1) state_nxt = ST_IDLE;
            ST_IDLE:  if (bus_in == 1'b0) state_nxt = ST_SHIFT;
            ST_SHIFT: if (sr_done)        state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = accept ? ST_ACK : ST_ARM;
            ST_ACK:   if (ack_cnt == ACW'(ACK_CYCLES - 1)) state_nxt = ST_ARM;
            default:  state_nxt = ST_ARM;
        endcase
    end

    // FSM outputs: capture strobes and bus drive; drive drops with state on reset.
    always_comb begin
        sr_start = (state == ST_IDLE) && (bus_in == 1'b0);
        sr_shift = (state == ST_SHIFT);
        ack_en   = (state == ST_ACK);
        ack_val  = (state == ST_ACK);
    end

    // Ack length counter, only runs while acking.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)             ack_cnt <= '0;
        else if (state == ST_ACK) ack_cnt <= ack_cnt + ACW'(1);
        else                      ack_cnt <= '0;
    end

    // One-entry output buffer; a load in CHECK wins over the ready-driven clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_src   <= '0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_src   <= fr.src;
            out_data  <= fr.data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Error pulse for any rejection of a frame addressed to this node.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) err_pulse <= 1'b0;
        else          err_pulse <= rej_frame || rej_crc || rej_ovf;
    end

`ifdef BUS_FRAME_RECEIVER_ERR_CNT_EN
    // Saturating per-type reject counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_crc_cnt   <= '0;
            err_frame_cnt <= '0;
            err_ovf_cnt   <= '0;
        end else begin
            if (rej_crc   && (err_crc_cnt   != 8'hFF)) err_crc_cnt   <= err_crc_cnt   + 8'd1;
            if (rej_frame && (err_frame_cnt != 8'hFF)) err_frame_cnt <= err_frame_cnt + 8'd1;
            if (rej_ovf   && (err_ovf_cnt   != 8'hFF)) err_ovf_cnt   <= err_ovf_cnt   + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_frame_receiver.sv
// Directed bench for bus_frame_receiver. Inputs change on the falling edge and
// outputs are read on the falling edge, half a cycle from the sampling edge.
module tb_bus_frame_receiver;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        bus_in;
    logic [3:0]  my_addr;
    logic [3:0]  crc_ref;
    logic        ack_en, ack_val, out_valid, out_ready, err_pulse;
    logic [3:0]  out_src;
    logic [63:0] out_data;
`ifdef BUS_FRAME_RECEIVER_ERR_CNT_EN
    logic [7:0]  err_crc_cnt, err_frame_cnt, err_ovf_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    bus_frame_receiver #(.ACK_CYCLES(2)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus_in    (bus_in),
        .my_addr   (my_addr),
        .crc_ref   (crc_ref),
        .ack_en    (ack_en),
        .ack_val   (ack_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .out_data  (out_data),
`ifdef BUS_FRAME_RECEIVER_ERR_CNT_EN
        .err_crc_cnt   (err_crc_cnt),
        .err_frame_cnt (err_frame_cnt),
        .err_ovf_cnt   (err_ovf_cnt),
`endif
        .err_pulse (err_pulse)
    );

    localparam logic [63:0] DA = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] DB = 64'h1111_2222_3333_4444;
    localparam logic [63:0] DC = 64'hCAFE_F00D_5A5A_A5A5;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] mk(input logic [3:0] src, input logic [3:0] dst,
                                       input logic [1:0] dsz, input logic [63:0] data,
                                       input logic [3:0] crc, input logic endb);
        return {endb, crc, data, dsz, dst, src, 1'b0};
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            bus_in = 1'b1;
        end
    endtask

    // Drives bits 0..79, the sender's forced 0, then releases the bus.
    // Returns between edges T+80 and T+81. rdy_chk >= 0 sets out_ready for CHECK.
    task automatic send_frame(input logic [79:0] f, input int rdy_chk);
        for (int k = 0; k < 80; k++) begin
            @(negedge clock);
            bus_in = f[k];
        end
        @(negedge clock);
        bus_in = 1'b0;
        if (rdy_chk >= 0) out_ready = rdy_chk[0];
        @(negedge clock);
        bus_in = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0; bus_in = 1'b1; out_ready = 1'b1;
        my_addr = 4'd5; crc_ref = 4'hA;
        repeat (3) @(negedge clock);
        chk("rst_ack_en", 64'(ack_en), 64'd0);
        chk("rst_ack_val", 64'(ack_val), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_src", 64'(out_src), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_err", 64'(err_pulse), 64'd0);
        reset_n = 1'b1;
        idle(3);

        // Valid frame
        send_frame(mk(4'd3, 4'd5, 2'b11, DA, 4'hA, 1'b1), -1);
        chk("ok_valid", 64'(out_valid), 64'd1);
        chk("ok_src", 64'(out_src), 64'd3);
        chk("ok_data", out_data, DA);
        chk("ok_err", 64'(err_pulse), 64'd0);
        chk("ok_ack_t81", 64'(ack_en), 64'd1);
        chk("ok_ackval", 64'(ack_val), 64'd1);
        @(negedge clock);
        chk("ok_ack_t82", 64'(ack_en), 64'd1);
        chk("ok_valid_clr", 64'(out_valid), 64'd0);
        @(negedge clock);
        chk("ok_ack_end", 64'(ack_en), 64'd0);
        idle(4);

        // Other destination: silent drop, then a frame is still accepted
        send_frame(mk(4'd3, 4'd6, 2'b11, DA, 4'hA, 1'b1), -1);
        chk("dst_valid", 64'(out_valid), 64'd0);
        chk("dst_err", 64'(err_pulse), 64'd0);
        chk("dst_ack", 64'(ack_en), 64'd0);
        idle(8);
        send_frame(mk(4'd7, 4'd5, 2'b11, DB, 4'hA, 1'b1), -1);
        chk("dst_next_valid", 64'(out_valid), 64'd1);
        chk("dst_next_src", 64'(out_src), 64'd7);
        chk("dst_next_data", out_data, DB);
        idle(4);

        // CRC reject
        send_frame(mk(4'd3, 4'd5, 2'b11, DA, 4'hB, 1'b1), -1);
        chk("crc_err", 64'(err_pulse), 64'd1);
        chk("crc_ack", 64'(ack_en), 64'd0);
        chk("crc_valid", 64'(out_valid), 64'd0);
        @(negedge clock);
        chk("crc_err_1cyc", 64'(err_pulse), 64'd0);
        chk("crc_ack2", 64'(ack_en), 64'd0);
        idle(3);

        // End bit 0: framing reject
        send_frame(mk(4'd3, 4'd5, 2'b11, DA, 4'hA, 1'b0), -1);
        chk("end_err", 64'(err_pulse), 64'd1);
        chk("end_ack", 64'(ack_en), 64'd0);
        chk("end_valid", 64'(out_valid), 64'd0);
`ifdef BUS_FRAME_RECEIVER_ERR_CNT_EN
        chk("end_frame_cnt", 64'(err_frame_cnt), 64'd1);
        chk("end_crc_cnt", 64'(err_crc_cnt), 64'd1);
`endif
        idle(4);

        // Short datasize: framing reject
        send_frame(mk(4'd3, 4'd5, 2'b01, DA, 4'hA, 1'b1), -1);
        chk("dsz_err", 64'(err_pulse), 64'd1);
        chk("dsz_ack", 64'(ack_en), 64'd0);
`ifdef BUS_FRAME_RECEIVER_ERR_CNT_EN
        chk("dsz_frame_cnt", 64'(err_frame_cnt), 64'd2);
`endif
        idle(4);

        // Buffer held, second frame overflows, third accepted with ready in CHECK
        out_ready = 1'b0;
        send_frame(mk(4'd1, 4'd5, 2'b11, DA, 4'hA, 1'b1), -1);
        chk("ovf_first_valid", 64'(out_valid), 64'd1);
        chk("ovf_first_ack", 64'(ack_en), 64'd1);
        idle(4);
        send_frame(mk(4'd2, 4'd5, 2'b11, DB, 4'hA, 1'b1), -1);
        chk("ovf_err", 64'(err_pulse), 64'd1);
        chk("ovf_ack", 64'(ack_en), 64'd0);
        chk("ovf_valid_held", 64'(out_valid), 64'd1);
        chk("ovf_src_held", 64'(out_src), 64'd1);
        chk("ovf_data_held", out_data, DA);
`ifdef BUS_FRAME_RECEIVER_ERR_CNT_EN
        chk("ovf_cnt", 64'(err_ovf_cnt), 64'd1);
`endif
        idle(4);
        send_frame(mk(4'd9, 4'd5, 2'b11, DC, 4'hA, 1'b1), 1);
        chk("rdy_chk_valid", 64'(out_valid), 64'd1);
        chk("rdy_chk_src", 64'(out_src), 64'd9);
        chk("rdy_chk_data", out_data, DC);
        chk("rdy_chk_err", 64'(err_pulse), 64'd0);
        chk("rdy_chk_ack", 64'(ack_en), 64'd1);
        @(negedge clock);
        chk("rdy_chk_clr", 64'(out_valid), 64'd0);
        idle(4);

        // Reset mid-frame with a frame held in the buffer
        out_ready = 1'b0;
        send_frame(mk(4'd4, 4'd5, 2'b11, DB, 4'hA, 1'b1), -1);
        idle(4);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        begin
            logic [79:0] fe;
            fe = mk(4'd6, 4'd5, 2'b11, DC, 4'hA, 1'b1);
            for (int k = 0; k < 40; k++) begin
                @(negedge clock);
                bus_in = fe[k];
            end
        end
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_src", 64'(out_src), 64'd0);
        chk("mid_rst_data", out_data, 64'd0);
        chk("mid_rst_ack", 64'(ack_en), 64'd0);
        @(negedge clock);
        reset_n = 1'b1; out_ready = 1'b1; bus_in = 1'b1;
        idle(3);
        send_frame(mk(4'd8, 4'd5, 2'b11, DC, 4'hA, 1'b1), -1);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_src", 64'(out_src), 64'd8);
        chk("post_rst_data", out_data, DC);
        chk("post_rst_ack", 64'(ack_en), 64'd1);

        // Reset mid-ack drops the drive at once
        reset_n = 1'b0;
        #1;
        chk("ack_rst_ack", 64'(ack_en), 64'd0);
        chk("ack_rst_valid", 64'(out_valid), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
